// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: input conditioning, run/pause/adjust mode FSM,
// counter increment strobes and adjust-mode blink blanking. Optional lap freeze (LAP_EN).
// Latency: strobes one cycle after the tick; press acts DB_CYCLES+3 cycles after raw edge.
// No backpressure: tick strobes are consumed in the cycle they arrive.

// Two-flop synchronizer plus debounce; emits a one-cycle pulse on an accepted 0->1.
module stopwatch_ctrl_db #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    logic [1:0]      sync_q, sync_d;
    logic            acc_q, acc_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    // Accept a new level only after it has held for DB_CYCLES consecutive cycles.
    always_comb begin
        sync_d = {sync_q[0], raw};
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (sync_q[1] == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            acc_d = sync_q[1];
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
        press_d = acc_d & ~acc_q;
    end

    // Synchronizer, debounce and press pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int DB_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic sw_adjust,
    input  logic sw_select,
    input  logic btn_lap,
    input  logic tick_1hz,
    input  logic tick_2hz,
    input  logic tick_blink,
    input  logic sec_at_max,
    output logic inc_sec,
    output logic inc_min,
    output logic blank_sec,
    output logic blank_min,
    output logic running,
    output logic freeze
);
    typedef enum logic [1:0] {ST_PAUSED = 2'd0, ST_RUN = 2'd1, ST_ADJ = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [1:0] adj_sync_q, adj_sync_d;
    logic [1:0] sel_sync_q, sel_sync_d;
    logic       resume_q, resume_d;
    logic       phase_q, phase_d;
    logic       inc_sec_q, inc_sec_d;
    logic       inc_min_q, inc_min_d;
    logic       running_q, running_d;
    logic       freeze_q, freeze_d;
    logic       pause_press;
    logic       adj_s, sel_s;

    stopwatch_ctrl_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_pause (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_pause),
        .press (pause_press)
    );

`ifdef LAP_EN
    logic lap_press;
    stopwatch_ctrl_db #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_lap),
        .press (lap_press)
    );
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    assign adj_s = adj_sync_q[1];
    assign sel_s = sel_sync_q[1];

    // Mode FSM, resume/blink bookkeeping and strobes decided by the pre-transition state.
    always_comb begin
        adj_sync_d = {adj_sync_q[0], sw_adjust};
        sel_sync_d = {sel_sync_q[0], sw_select};
        state_d    = state_q;
        resume_d   = resume_q;
        phase_d    = phase_q;
        inc_sec_d  = 1'b0;
        inc_min_d  = 1'b0;
        freeze_d   = freeze_q;

        case (state_q)
            ST_PAUSED, ST_RUN: begin
                if (adj_s) begin
                    state_d  = ST_ADJ;
                    // A press in the entry cycle flips the captured resume flag.
                    resume_d = (state_q == ST_RUN) ^ pause_press;
                    phase_d  = 1'b0;
                end else if (pause_press) begin
                    state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
                end
            end
            ST_ADJ: begin
                if (!adj_s) begin
                    state_d = (resume_q ^ pause_press) ? ST_RUN : ST_PAUSED;
                    phase_d = 1'b0;
                end else begin
                    if (pause_press) resume_d = ~resume_q;
                    if (tick_blink)  phase_d  = ~phase_q;
                end
            end
            default: state_d = ST_PAUSED;
        endcase

        if (state_q == ST_RUN) begin
            inc_sec_d = tick_1hz;
            inc_min_d = tick_1hz & sec_at_max;
        end else if (state_q == ST_ADJ && tick_2hz) begin
            inc_sec_d = sel_s;
            inc_min_d = ~sel_s;
        end

`ifdef LAP_EN
        if (state_d == ST_ADJ) begin
            freeze_d = 1'b0;
        end else if (lap_press && state_q != ST_ADJ) begin
            freeze_d = ~freeze_q;
        end
`else
        freeze_d = 1'b0;
`endif
        running_d = (state_d == ST_RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_PAUSED;
            adj_sync_q <= '0;
            sel_sync_q <= '0;
            resume_q   <= 1'b0;
            phase_q    <= 1'b0;
            inc_sec_q  <= 1'b0;
            inc_min_q  <= 1'b0;
            running_q  <= 1'b0;
            freeze_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            adj_sync_q <= adj_sync_d;
            sel_sync_q <= sel_sync_d;
            resume_q   <= resume_d;
            phase_q    <= phase_d;
            inc_sec_q  <= inc_sec_d;
            inc_min_q  <= inc_min_d;
            running_q  <= running_d;
            freeze_q   <= freeze_d;
        end
    end

    assign inc_sec   = inc_sec_q;
    assign inc_min   = inc_min_q;
    assign running   = running_q;
    assign freeze    = freeze_q;
    assign blank_sec = phase_q & sel_s;
    assign blank_min = phase_q & ~sel_s;
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch datapath. Conditions the raw pause button and the adjust/select switches, runs the run/pause/adjust mode FSM and issues single-cycle increment strobes to the minutes/seconds counters. Also drives per-field blank controls to the display for adjust-mode blinking. Sits between the board inputs, the clock divider tick strobes, and the stopwatch counter and display blocks.

Parameters:
DB_CYCLES, 1000000, consecutive clk cycles a synchronized button level must hold before it is accepted (10 ms at 100 MHz).
DB_W, 20, width of the debounce counter; must satisfy 2^DB_W > DB_CYCLES.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
btn_pause  input  1  raw pause pushbutton, asynchronous
sw_adjust  input  1  raw adjust switch, asynchronous; 1 = adjust mode
sw_select  input  1  raw select switch, asynchronous; 1 = seconds field, 0 = minutes field
btn_lap  input  1  raw lap pushbutton; used only with LAP_EN
tick_1hz  input  1  one-clk-cycle strobe at 1 Hz from the divider
tick_2hz  input  1  one-clk-cycle strobe at 2 Hz
tick_blink  input  1  one-clk-cycle strobe at the blink rate (4 Hz)
sec_at_max  input  1  seconds counter currently equals 59
inc_sec  output  1  one-cycle strobe: seconds counter +1, wrapping 59->0
inc_min  output  1  one-cycle strobe: minutes counter +1, wrapping 59->0
blank_sec  output  1  display blanks the seconds digits
blank_min  output  1  display blanks the minutes digits
running  output  1  1 while in RUN
freeze  output  1  display holds its latched value (lap)

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer and debounce state 0, FSM = PAUSED, resume flag 0, blink phase 0, all outputs 0.
- Sync: each raw input passes through a 2-flop synchronizer. Switches are used directly after the synchronizer.
- Debounce (btn_pause, btn_lap): the accepted level changes only after the synced level has differed from it for DB_CYCLES consecutive cycles. The counter clears whenever the synced level equals the accepted level.
- A press is the accepted level going 0->1. It produces a one-cycle internal pulse. Release has no effect.
- Worst-case latency from raw edge to press pulse: DB_CYCLES+3 cycles.
- FSM states: PAUSED, RUN, ADJ.
- In PAUSED and RUN, a press toggles between PAUSED and RUN.
- From any state, synced adjust=1 moves to ADJ on the next edge. On entry, resume flag := (state==RUN) and blink phase := 0.
- In ADJ, a press toggles the resume flag.
- In ADJ, synced adjust=0 exits to RUN if resume=1, otherwise to PAUSED.
- If adjust=1 and a press occur in the same cycle while in RUN/PAUSED: go to ADJ, and the press toggles the captured resume flag.
- Strobes are registered, one cycle after the tick, and decided by the state at the tick cycle:
  - RUN: on tick_1hz, inc_sec=1. If sec_at_max=1 in that cycle, inc_min=1 in the same cycle (carry).
  - ADJ: on tick_2hz, inc_sec=1 if select=1, else inc_min=1. No carry; tick_1hz is ignored.
  - PAUSED: no strobes.
- A tick coinciding with a state transition uses the pre-transition state.
- Blink: in ADJ, the blink phase toggles on tick_blink. blank_sec = phase & select; blank_min = phase & ~select. Outside ADJ both are 0 and the phase is held at 0.
- running = (state==RUN), registered.

Optional Feature:
LAP_EN: when defined, a btn_lap press (debounced, same rules as pause) toggles freeze, but only while in RUN or PAUSED.
- freeze clears on reset and on entry to ADJ.
- Counting is unaffected while freeze=1.
- When LAP_EN is not defined: the btn_lap logic is not instantiated, btn_lap is ignored and freeze is constant 0. The port list is identical in both builds.

Test Plan:
- Reset, DB_CYCLES=4: all outputs 0, state PAUSED; drive tick_1hz for 3 strobes -> no inc_sec.
- Press pause held 10 cycles -> running=1 within 7 cycles. Then tick_1hz with sec_at_max=0 -> inc_sec=1 for exactly 1 cycle and inc_min=0. Then tick_1hz with sec_at_max=1 -> inc_sec=1 and inc_min=1 in the same cycle.
- Bounce btn_pause with toggles every 2 cycles for 20 cycles, then release -> no state change.
- RUN, set adjust=1, select=0 -> running=0. tick_2hz x3 -> 3 inc_min pulses and no inc_sec. tick_blink x2 -> blank_min 1 then 0, blank_sec stays 0. Clear adjust -> back to RUN (resume=1).
- PAUSED, enter ADJ, press pause once, clear adjust -> RUN. Assert rst=0 mid-ADJ asynchronously -> outputs 0 and state PAUSED without waiting for a clk edge.
- LAP_EN build, RUN, press lap -> freeze=1 while inc_sec continues on tick_1hz. Set adjust=1 -> freeze=0. Non-LAP_EN build: lap press leaves freeze=0.
